// File: rtl/pdiv.sv
// pdiv: combinational restoring divider, q = a / b and r = a % b; purely combinational, no handshake.
// With b == 0 every trial subtraction succeeds, so q is all ones and r equals a.
module pdiv #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q,
  output logic [W-1:0] r
);

  logic [W:0] rem;

  always_comb begin
    rem = '0;
    q   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      rem = {rem[W-1:0], a[i]};
      if (rem >= {1'b0, b}) begin
        rem  = rem - {1'b0, b};
        q[i] = 1'b1;
      end
    end
    r = rem[W-1:0];
  end

endmodule

// File: rtl/pdiv_arbiter.sv
// pdiv_arbiter: round-robin share of one pdiv between two requesters; accept-to-response 2 cycles, one op per 3 cycles.
// A response is held until its owner's ready and nothing is accepted meanwhile; optional PDIV_ARB_DIV0_CHECK_EN.
module pdiv_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         resp0_valid,
  output logic [W-1:0] resp0_q,
  output logic [W-1:0] resp0_r,
  output logic         resp0_err,
  input  logic         resp0_ready,
  output logic         resp1_valid,
  output logic [W-1:0] resp1_q,
  output logic [W-1:0] resp1_r,
  output logic         resp1_err,
  input  logic         resp1_ready,
  output logic         busy,
  output logic [7:0]   op_count
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  typedef struct packed {
    logic         err;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } res_t;

  state_t       state, next_state;
  logic [W-1:0] op_a, op_b;
  logic         owner;
  logic         last_grant;
  res_t         res, calc_res;
  logic [7:0]   cnt;
  logic [W-1:0] div_q, div_r;
  logic         grant0, grant1;
  logic         acc0, acc1;
  logic         resp_done;

  pdiv #(.W(W)) u_pdiv (
    .a (op_a),
    .b (op_b),
    .q (div_q),
    .r (div_r)
  );

  // Contention goes to whoever did not win last time.
  assign grant1    = req1_valid && (!req0_valid || !last_grant);
  assign grant0    = req0_valid && !grant1;
  assign acc0      = (state == IDLE) && grant0;
  assign acc1      = (state == IDLE) && grant1;
  assign resp_done = (state == RESP) && (owner ? resp1_ready : resp0_ready);

`ifdef PDIV_ARB_DIV0_CHECK_EN
  always_comb begin
    if (op_b == '0) calc_res = '{err: 1'b1, q: {W{1'b1}}, r: op_a};
    else            calc_res = '{err: 1'b0, q: div_q,     r: div_r};
  end
`else
  assign calc_res = '{err: 1'b0, q: div_q, r: div_r};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (acc0 || acc1) next_state = CALC;
      CALC:    next_state = RESP;
      RESP:    if (resp_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = acc0;
    req1_ready  = acc1;
    busy        = (state != IDLE);
    resp0_valid = (state == RESP) && !owner;
    resp1_valid = (state == RESP) && owner;
    resp0_q     = resp0_valid ? res.q   : '0;
    resp0_r     = resp0_valid ? res.r   : '0;
    resp0_err   = resp0_valid ? res.err : 1'b0;
    resp1_q     = resp1_valid ? res.q   : '0;
    resp1_r     = resp1_valid ? res.r   : '0;
    resp1_err   = resp1_valid ? res.err : 1'b0;
    op_count    = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      res        <= '0;
      cnt        <= '0;
    end else begin
      if (acc0 || acc1) begin
        op_a       <= acc1 ? req1_a : req0_a;
        op_b       <= acc1 ? req1_b : req0_b;
        owner      <= acc1;
        last_grant <= acc1;
      end
      if (state == CALC) res <= calc_res;
      if (resp_done)     cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pdiv_arbiter.sv
// Directed bench for pdiv_arbiter: vector table plus hold, contention, reset and wrap sequences.
module tb_pdiv_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic [3:0] resp0_q, resp0_r, resp1_q, resp1_r;
  logic       resp0_ready, resp1_ready;
  logic       busy;
  logic [7:0] op_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_cnt;

  always #5 clk = ~clk;

  pdiv_arbiter #(.W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_q(resp0_q), .resp0_r(resp0_r), .resp0_err(resp0_err),
    .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_q(resp1_q), .resp1_r(resp1_r), .resp1_err(resp1_err),
    .resp1_ready(resp1_ready),
    .busy(busy), .op_count(op_count)
  );

  typedef struct {
    bit         sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input bit s);
    return s ? req1_ready : req0_ready;
  endfunction
  function automatic logic rv(input bit s);
    return s ? resp1_valid : resp0_valid;
  endfunction
  function automatic logic [3:0] rq(input bit s);
    return s ? resp1_q : resp0_q;
  endfunction
  function automatic logic [3:0] rr(input bit s);
    return s ? resp1_r : resp0_r;
  endfunction
  function automatic logic re(input bit s);
    return s ? resp1_err : resp0_err;
  endfunction

  task automatic clear_inputs();
    req0_valid = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0;
    resp0_ready = 0; resp1_ready = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_cnt = 0;
  endtask

  task automatic wait_ready(input bit s, input string name);
    int n = 0;
    @(negedge clk);
    while (!rdy(s) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(name, rdy(s), 1);
  endtask

  // One complete operation with the response taken immediately; cqr=0 skips q/r checks.
  task automatic do_op(input bit s, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] eq, input logic [3:0] er, input logic eerr, input bit cqr);
    @(posedge clk); #1;
    if (s) begin req1_valid = 1; req1_a = a; req1_b = b; resp1_ready = 1; end
    else   begin req0_valid = 1; req0_a = a; req0_b = b; resp0_ready = 1; end
    wait_ready(s, "op_req_ready");
    chk("op_other_ready", rdy(!s), 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk("op_calc_busy", busy, 1);
    chk("op_calc_no_resp", rv(s), 0);
    @(negedge clk);
    chk("op_resp_valid", rv(s), 1);
    chk("op_other_resp_valid", rv(!s), 0);
    if (cqr) begin
      chk("op_q", rq(s), eq);
      chk("op_r", rr(s), er);
    end
    chk("op_err", re(s), eerr);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    resp0_ready = 0; resp1_ready = 0;
    @(negedge clk);
    chk("op_idle_busy", busy, 0);
    chk("op_count", op_count, exp_cnt);
    chk("op_resp_dropped", rv(s), 0);
  endtask

  initial begin
    vec_t vecs[8];
    int   grants[8];
    int   ng, nresp, n, badq;

    vecs[0] = '{0, 4'd6,  4'd2,  4'd3,  4'd0};
    vecs[1] = '{1, 4'd15, 4'd4,  4'd3,  4'd3};
    vecs[2] = '{0, 4'd15, 4'd1,  4'd15, 4'd0};
    vecs[3] = '{1, 4'd3,  4'd7,  4'd0,  4'd3};
    vecs[4] = '{0, 4'd9,  4'd3,  4'd3,  4'd0};
    vecs[5] = '{1, 4'd14, 4'd5,  4'd2,  4'd4};
    vecs[6] = '{0, 4'd0,  4'd5,  4'd0,  4'd0};
    vecs[7] = '{1, 4'd13, 4'd13, 4'd1,  4'd0};

    clear_inputs();
    rst = 1;
    exp_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state, then ready follows valid combinationally.
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_resp0_valid", resp0_valid, 0);
    chk("rst_resp1_valid", resp1_valid, 0);
    chk("rst_resp_data", {resp0_q, resp0_r, resp1_q, resp1_r}, 0);
    chk("rst_resp_err", {resp0_err, resp1_err}, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_ready_idle", {req0_ready, req1_ready}, 0);
    req1_valid = 1;
    #1;
    chk("rst_req1_ready", req1_ready, 1);
    chk("rst_req0_ready", req0_ready, 0);
    req1_valid = 0;

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0, 1'b1);

    // Response held while owner withholds ready; non-owner ready and req0 both ignored.
    @(posedge clk); #1;
    req1_valid = 1; req1_a = 9; req1_b = 4;
    wait_ready(1'b1, "hold_req1_ready");
    @(posedge clk); #1;
    req1_valid = 0;
    req0_valid = 1; req0_a = 7; req0_b = 3; resp0_ready = 1;
    @(negedge clk);
    chk("hold_calc_req0_ready", req0_ready, 0);
    @(negedge clk);
    chk("hold_resp1_valid", resp1_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", resp1_valid, 1);
      chk("hold_q", resp1_q, 2);
      chk("hold_r", resp1_r, 1);
      chk("hold_busy", busy, 1);
      chk("hold_req0_ready", req0_ready, 0);
      chk("hold_resp0_zero", {resp0_valid, resp0_q, resp0_r, resp0_err}, 0);
    end
    @(posedge clk); #1;
    resp1_ready = 1;
    @(posedge clk); #1;
    resp1_ready = 0;
    exp_cnt = exp_cnt + 8'd1;
    @(negedge clk);
    chk("hold_release_busy", busy, 0);
    chk("hold_release_req0_ready", req0_ready, 1);
    chk("hold_release_count", op_count, exp_cnt);
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("hold_next_valid", resp0_valid, 1);
    chk("hold_next_qr", {resp0_q, resp0_r}, {4'd2, 4'd1});
    @(posedge clk); #1;
    resp0_ready = 0;
    exp_cnt = exp_cnt + 8'd1;
    @(negedge clk);
    chk("hold_next_count", op_count, exp_cnt);

`ifdef PDIV_ARB_DIV0_CHECK_EN
    do_op(1'b0, 4'd10, 4'd0, 4'd15, 4'd10, 1'b1, 1'b1);
`else
    do_op(1'b0, 4'd10, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
`endif

    // Reset during CALC drops the operation.
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 4; req0_b = 1; resp0_ready = 1;
    wait_ready(1'b0, "rcalc_req0_ready");
    @(posedge clk); #1;
    req0_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0; exp_cnt = 0;
    @(negedge clk);
    chk("rcalc_busy", busy, 0);
    chk("rcalc_resp0_valid", resp0_valid, 0);
    chk("rcalc_count", op_count, 0);
    @(negedge clk);
    chk("rcalc_resp0_late", resp0_valid, 0);

    // Reset during RESP; last winner was requester 0, so reset must restore last_grant.
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 10; req0_b = 3; resp0_ready = 0;
    wait_ready(1'b0, "rresp_req0_ready");
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rresp_valid_before", resp0_valid, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; exp_cnt = 0;
    @(negedge clk);
    chk("rresp_valid", {resp0_valid, resp1_valid}, 0);
    chk("rresp_data", {resp0_q, resp0_r, resp0_err}, 0);
    chk("rresp_busy", busy, 0);
    chk("rresp_count", op_count, 0);

    // Continuous contention: grants alternate 0,1,0,1 starting with requester 0.
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 5; req0_b = 2; resp0_ready = 1;
    req1_valid = 1; req1_a = 2; req1_b = 5; resp1_ready = 1;
    ng = 0; nresp = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("cont_one_ready", {1'b0, req0_ready & req1_ready}, 0);
      if (ng < 8 && req0_ready) begin grants[ng] = 0; ng++; end
      else if (ng < 8 && req1_ready) begin grants[ng] = 1; ng++; end
      if (resp0_valid) begin
        chk("cont_resp0_qr", {resp0_q, resp0_r}, {4'd2, 4'd1});
        nresp++;
      end
      if (resp1_valid) begin
        chk("cont_resp1_qr", {resp1_q, resp1_r}, {4'd0, 4'd2});
        nresp++;
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    chk("cont_grants", ng, 4);
    chk("cont_resps", nresp, 4);
    for (int k = 0; k < 4; k++) chk("cont_grant_seq", grants[k], k % 2);
    @(negedge clk);
    chk("cont_count", op_count, 4);

    // 256 back-to-back operations wrap the counter.
    do_reset();
    req0_valid = 1; req0_a = 6; req0_b = 2; resp0_ready = 1;
    n = 0; badq = 0;
    for (int cyc = 0; cyc < 1000 && n < 256; cyc++) begin
      @(negedge clk);
      if (resp0_valid) begin
        if (n == 1)   chk("wrap_count_1", op_count, 1);
        if (n == 255) chk("wrap_count_255", op_count, 255);
        if ({resp0_q, resp0_r} !== {4'd3, 4'd0}) badq++;
        n++;
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk("wrap_ops", n, 256);
    chk("wrap_bad_results", badq, 0);
    chk("wrap_count_0", op_count, 0);
    chk("wrap_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
